// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared state encoding and defaults for the adder-lane arbiter
package fp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner select
// Scans req starting at rr_ptr and wrapping; returns the first set bit one-hot.
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               found
);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr is always below NUM_REQ, so one subtraction is enough to wrap
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) begin
        pos = pos - (PTR_W+1)'(NUM_REQ);
      end
      idx = pos[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin time-sharing of one FP adder lane with a watchdog
// One operation in flight; the result is steered back to the requester that owns it.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_operand_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_operand_b,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [DATA_WIDTH-1:0]               req_result,
  output logic [NUM_REQ-1:0]                  req_result_ready,
  output logic [DATA_WIDTH-1:0]               add_operand_a,
  output logic [DATA_WIDTH-1:0]               add_operand_b,
  output logic                                add_start,
  input  logic [DATA_WIDTH-1:0]               add_result,
  input  logic                                add_result_ready,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   owner_inc;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_found;
  logic [WD_W-1:0]    wd_count;
  logic               wd_expired;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .winner (win_onehot),
    .found  (win_found)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  assign owner_inc  = (owner == PTR_LAST) ? '0 : owner + 1'b1;
  assign wd_expired = (wd_count == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (win_found) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (add_result_ready) begin
          state_next = RESP;
        end else if (wd_expired) begin
          state_next = IDLE;
        end
      end
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a flop; strobes are cleared each cycle and set only on the entry edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr           <= '0;
      owner            <= '0;
      wd_count         <= '0;
      req_grant        <= '0;
      req_result       <= '0;
      req_result_ready <= '0;
      add_operand_a    <= '0;
      add_operand_b    <= '0;
      add_start        <= 1'b0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      req_grant        <= '0;
      req_result_ready <= '0;
      add_start        <= 1'b0;
      busy             <= (state_next != IDLE);
      unique case (state)
        IDLE: begin
          if (win_found) begin
            owner         <= win_idx;
            req_grant     <= win_onehot;
            add_operand_a <= req_operand_a[win_idx];
            add_operand_b <= req_operand_b[win_idx];
            add_start     <= 1'b1;
          end
        end
        ISSUE: begin
          wd_count <= '0;
        end
        WAIT: begin
          if (add_result_ready) begin
            req_result              <= add_result;
            req_result_ready[owner] <= 1'b1;
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            rr_ptr      <= owner_inc;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= owner_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
